instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage of the accumulator CPU, directly downstream of program_counter.
//  - Takes the current PC and reads the instruction word from program memory.
//  - Returns PC+1 to program_counter.
//  - Drives the program_counter enable.
//  - Owns program memory, which a host loader fills in a LOAD phase before execution.
// PARAMETERS
//  MSB      11  PC/address width; memory depth = 2**MSB words
//  INSTR_W  16  instruction width = opcode[INSTR_W-1:MSB] (5b) + operand[MSB-1:0]
// PORTS
//  i_clk          in   1        clock, all state updates on rising edge
//  i_rst          in   1        reset, synchronous, active-high
//  i_pc           in   MSB      current PC from program_counter
//  i_load_we      in   1        loader write strobe (LOAD state only)
//  i_load_addr    in   MSB      loader write address
//  i_load_data    in   INSTR_W  loader write data
//  i_start        in   1        leave LOAD, begin execution
//  i_step         in   1        single-step pulse (only with FETCH_STEP_EN)
//  o_inc          out  MSB      i_pc+1 to program_counter
//  o_pc_en        out  1        program_counter update enable
//  o_instr        out  INSTR_W  registered instruction to decode stage
//  o_instr_valid  out  1        o_instr holds a freshly fetched word this cycle
//  o_halted       out  1        HALT opcode fetched; execution stopped
//  o_state        out  2        LOAD=00, RUN=01, HALT=10 (debug)
// BEHAVIOUR
//  - Reset: state=LOAD; o_instr=0; o_instr_valid=0; o_halted=0; o_pc_en=0.
//    Memory contents are NOT cleared by reset.
//  - Memory: synchronous write, asynchronous read; rd_data = mem[i_pc] combinationally.
//  - o_inc = (i_pc+1) mod 2**MSB; 2**MSB-1 wraps to 0. Combinational in every state.
//  - LOAD state:
//    - i_load_we writes mem[i_load_addr] <= i_load_data.
//    - i_start -> RUN; a write in the same cycle still completes.
//    - o_pc_en=0; o_instr_valid=0.
//  - RUN state:
//    - o_pc_en = (rd_data opcode != OPC_HALT); combinational.
//    - Each edge: o_instr <= rd_data; o_instr_valid <= 1.
//      Latency: word at PC p appears on o_instr 1 cycle after p is presented.
//    - rd_data opcode == OPC_HALT (5'b00000): PC is not enabled that cycle (stays at halt address).
//      Edge: o_instr <= HALT word, o_instr_valid <= 1, o_halted <= 1, state -> HALT.
//  - HALT state:
//    - o_pc_en=0; o_instr holds HALT word; o_instr_valid=0 from next cycle; o_halted=1.
//    - Exit only via i_rst.
//  - Ignored inputs:
//    - i_load_we in RUN/HALT: ignored, memory unchanged.
//    - i_start in RUN/HALT: ignored.
//  - Reset mid-RUN: next cycle state=LOAD, outputs at reset values, program preserved.
//    Re-issuing i_start re-runs the program (program_counter is reset by the same i_rst).
// CONFIGURATION
//  FETCH_STEP_EN defined:
//   - i_step port exists.
//   - In RUN, o_pc_en and o_instr/o_instr_valid capture qualified by i_step=1.
//   - Without i_step: o_pc_en=0, o_instr holds, o_instr_valid=0.
//   - HALT detection also occurs only on a stepped cycle.
//  FETCH_STEP_EN undefined: no i_step port; RUN is free-running as above.
// STRUCTURE
//  - bip_pkg holds:
//    - constants INSTR_W=16, OPC_W=5, OPC_HALT=5'b00000
//    - state encodings ST_LOAD/ST_RUN/ST_HALT
//  - Sub-module instr_mem:
//    - params MSB, INSTR_W; ports i_clk, i_we, i_waddr, i_wdata, i_raddr, o_rdata.
//    - Async read, sync write.
//  - Top holds the FSM, o_inc adder, and the instruction register.
// TESTING
//  1 Reset -> o_state=00, o_pc_en=0, o_instr=0, o_instr_valid=0, o_halted=0.
//  2 Load mem[0..2]=16'h0805,16'h1003,16'h0000; i_start; PC fed from o_inc via program_counter
//    -> o_instr 0805, 1003, 0000 on consecutive cycles; o_halted=1; PC frozen at 2.
//  3 i_load_we during RUN to addr 1 with 16'hFFFF -> mem[1] unchanged; readback after reset = 16'h1003.
//  4 i_pc=11'h7FF -> o_inc=11'h000 (wrap).
//  5 Assert i_rst two cycles into RUN -> state LOAD next cycle; second i_start reproduces the scenario 2 stream.
//  6 FETCH_STEP_EN: three i_step pulses spaced 4 cycles -> exactly 3 o_instr_valid pulses; PC advances 0->1->2, then halts.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared constants and state encodings for the accumulator CPU fetch path.
package bip_pkg;

    localparam int INSTR_W = 16;
    localparam int OPC_W   = 5;
    localparam logic [OPC_W-1:0] OPC_HALT = 5'b00000;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: program_counter/loader side is master, fetch unit is slave.
// i_step only exists when FETCH_STEP_EN is defined.
interface instr_fetch_unit_if #(
    parameter int MSB     = 11,
    parameter int INSTR_W = 16
);

    logic [MSB-1:0]     i_pc;
    logic               i_load_we;
    logic [MSB-1:0]     i_load_addr;
    logic [INSTR_W-1:0] i_load_data;
    logic               i_start;
`ifdef FETCH_STEP_EN
    logic               i_step;
`endif
    logic [MSB-1:0]     o_inc;
    logic               o_pc_en;
    logic [INSTR_W-1:0] o_instr;
    logic               o_instr_valid;
    logic               o_halted;
    logic [1:0]         o_state;

    modport master (
        output i_pc, i_load_we, i_load_addr, i_load_data, i_start,
`ifdef FETCH_STEP_EN
        output i_step,
`endif
        input  o_inc, o_pc_en, o_instr, o_instr_valid, o_halted, o_state
    );

    modport slave (
        input  i_pc, i_load_we, i_load_addr, i_load_data, i_start,
`ifdef FETCH_STEP_EN
        input  i_step,
`endif
        output o_inc, o_pc_en, o_instr, o_instr_valid, o_halted, o_state
    );

endinterface

// File: rtl/instr_mem.sv
// Program memory: synchronous write, asynchronous (combinational) read.
module instr_mem #(
    parameter int MSB     = 11,
    parameter int INSTR_W = 16
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [MSB-1:0]     i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic [MSB-1:0]     i_raddr,
    output logic [INSTR_W-1:0] o_rdata
);

    logic [INSTR_W-1:0] mem [2**MSB];

    // Contents deliberately survive reset so a program can be re-run.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: LOAD/RUN/HALT FSM, PC+1 adder and instruction register.
// Define FETCH_STEP_EN to qualify RUN-state fetches with the i_step pulse.
module instr_fetch_unit
    import bip_pkg::*;
#(
    parameter int MSB     = 11,
    parameter int INSTR_W = bip_pkg::INSTR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    instr_fetch_unit_if.slave bus
);

    state_t             state_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic               valid_reg;
    logic               halted_reg;
    logic [INSTR_W-1:0] rd_data;
    logic               is_halt;
    logic               step_ok;
    logic               mem_we;

    // Loader writes are only honoured while the program is not executing.
    assign mem_we = (state_reg == ST_LOAD) && bus.i_load_we;

    instr_mem #(
        .MSB     (MSB),
        .INSTR_W (INSTR_W)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (mem_we),
        .i_waddr (bus.i_load_addr),
        .i_wdata (bus.i_load_data),
        .i_raddr (bus.i_pc),
        .o_rdata (rd_data)
    );

`ifdef FETCH_STEP_EN
    assign step_ok = bus.i_step;
`else
    assign step_ok = 1'b1;
`endif

    assign is_halt = (rd_data[INSTR_W-1 -: OPC_W] == OPC_HALT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= ST_LOAD;
            instr_reg  <= '0;
            valid_reg  <= 1'b0;
            halted_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    valid_reg <= 1'b0;
                    if (bus.i_start) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (step_ok) begin
                        instr_reg <= rd_data;
                        valid_reg <= 1'b1;
                        if (is_halt) begin
                            halted_reg <= 1'b1;
                            state_reg  <= ST_HALT;
                        end
                    end else begin
                        valid_reg <= 1'b0;
                    end
                end
                ST_HALT: begin
                    valid_reg <= 1'b0;
                end
                default: begin
                    state_reg <= ST_LOAD;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // The PC must not move past a HALT word, so enable is decided combinationally.
    assign bus.o_pc_en       = (state_reg == ST_RUN) && step_ok && !is_halt;
    assign bus.o_inc         = bus.i_pc + 1'b1;
    assign bus.o_instr       = instr_reg;
    assign bus.o_instr_valid = valid_reg;
    assign bus.o_halted      = halted_reg;
    assign bus.o_state       = state_reg;

endmodule
